// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pkg
// Purpose  : RV32I base opcode constants, immediate-format enumeration and
//            small classification helpers shared by the decode stage and
//            the immediate generator (also used by the branch target unit).
// Revision : 1.0  initial release
// ============================================================================
package decode_stage_pkg;

  localparam logic [6:0] C_OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] C_OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] C_OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] C_OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] C_OPC_STORE    = 7'b0100011;
  localparam logic [6:0] C_OPC_OP       = 7'b0110011;
  localparam logic [6:0] C_OPC_LUI      = 7'b0110111;
  localparam logic [6:0] C_OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] C_OPC_JALR     = 7'b1100111;
  localparam logic [6:0] C_OPC_JAL      = 7'b1101111;
  localparam logic [6:0] C_OPC_SYSTEM   = 7'b1110011;

  // funct3 shared by SRL/SRA and SRLI/SRAI
  localparam logic [2:0] C_F3_SR = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // FENCE/SYSTEM deliberately map to IMM_NONE: their fields are not
  // consumed as an arithmetic immediate by this datapath.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      C_OPC_OP_IMM, C_OPC_LOAD, C_OPC_JALR: fmt = IMM_I;
      C_OPC_STORE:                          fmt = IMM_S;
      C_OPC_BRANCH:                         fmt = IMM_B;
      C_OPC_LUI, C_OPC_AUIPC:               fmt = IMM_U;
      C_OPC_JAL:                            fmt = IMM_J;
      default:                              fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode);
    logic legal;
    case (opcode)
      C_OPC_LOAD, C_OPC_MISC_MEM, C_OPC_OP_IMM, C_OPC_AUIPC, C_OPC_STORE,
      C_OPC_OP, C_OPC_LUI, C_OPC_BRANCH, C_OPC_JALR, C_OPC_JAL,
      C_OPC_SYSTEM: legal = 1'b1;
      default:      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Purpose  : Purely combinational RV32I immediate generator. Selects the
//            I/S/B/U/J layout from the opcode and sign-extends to XLEN.
//            R-type, FENCE/SYSTEM and illegal opcodes produce zero.
// Ports    : inst   [31:7]   instruction bits above the opcode field
//            opcode [6:0]    instruction opcode field
//            imm    [XLEN-1:0] sign-extended immediate
// Revision : 1.0  initial release
// ============================================================================
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  logic [6:0]      opcode,
  output logic [XLEN-1:0] imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (imm_fmt(opcode))
      IMM_I:   w_imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
      IMM_U:   w_imm32 = {inst[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Bit 31 is the sign for every format, so widening replicates it.
  assign imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I ID stage. Decodes {pc, inst} from fetch combinationally
//            and captures the fields into the ID/EX register on accept.
//            valid/ready handshake toward fetch and execute, flush, and a
//            saturating count of cycles stalled by execute.
// Ports    : clk, rst (async, active high)
//            if_valid/if_ready/if_pc/if_inst   fetch side
//            flush                             squash ID/EX and current accept
//            ex_ready                          execute consumes id_* this cycle
//            id_valid, id_pc, id_opcode, id_funct3, id_add_rshift_type,
//            id_rd, id_rs1, id_rs2, id_imm, id_illegal   ID/EX register
//            stall_cnt                         saturating stall counter
// Revision : 1.0  initial release
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_inst,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [6:0]       id_opcode,
  output logic [2:0]       id_funct3,
  output logic             id_add_rshift_type,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [XLEN-1:0]  id_imm,
  output logic             id_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  // --------------------------------------------------------------------------
  // Combinational decode of the presented instruction
  // --------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_add_rshift_type;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_accept;

  assign w_opcode  = if_inst[6:0];
  assign w_funct3  = if_inst[14:12];
  assign w_illegal = !is_legal(w_opcode);

  always_comb begin
    w_add_rshift_type = 1'b0;
    w_rd              = if_inst[11:7];
    w_rs1             = if_inst[19:15];
    w_rs2             = 5'd0;

    // OP-IMM only honours inst[30] for the shift-right group; for ADDI etc.
    // that bit is immediate data and must never turn an add into a subtract.
    if (w_opcode == C_OPC_OP) begin
      w_add_rshift_type = if_inst[30];
    end else if (w_opcode == C_OPC_OP_IMM && w_funct3 == C_F3_SR) begin
      w_add_rshift_type = if_inst[30];
    end

    if (w_opcode == C_OPC_OP || w_opcode == C_OPC_STORE ||
        w_opcode == C_OPC_BRANCH) begin
      w_rs2 = if_inst[24:20];
    end

    if (w_opcode == C_OPC_LUI || w_opcode == C_OPC_AUIPC ||
        w_opcode == C_OPC_JAL) begin
      w_rs1 = 5'd0;
    end

    if (w_opcode == C_OPC_STORE || w_opcode == C_OPC_BRANCH) begin
      w_rd = 5'd0;
    end
  end

  imm_gen #(
    .XLEN   (XLEN)
  ) u_imm_gen (
    .inst   (if_inst[31:7]),
    .opcode (w_opcode),
    .imm    (w_imm)
  );

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic id_valid_q, id_valid_d;

  assign if_ready = !id_valid_q || ex_ready;
  assign w_accept = if_valid && if_ready && !flush;

  // --------------------------------------------------------------------------
  // ID/EX register bank (single enable = accept)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  pc_q,        pc_d;
  logic [6:0]       opcode_q,    opcode_d;
  logic [2:0]       funct3_q,    funct3_d;
  logic             addrs_q,     addrs_d;
  logic [4:0]       rd_q,        rd_d;
  logic [4:0]       rs1_q,       rs1_d;
  logic [4:0]       rs2_q,       rs2_d;
  logic [XLEN-1:0]  imm_q,       imm_d;
  logic             illegal_q,   illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    id_valid_d  = id_valid_q;
    pc_d        = pc_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    addrs_d     = addrs_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    illegal_d   = illegal_q;
    stall_cnt_d = stall_cnt_q;

    // Flush wins; otherwise a new accept refills, otherwise a consume drains.
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (w_accept) begin
      id_valid_d = 1'b1;
    end else if (ex_ready) begin
      id_valid_d = 1'b0;
    end

    if (w_accept) begin
      pc_d      = if_pc;
      opcode_d  = w_opcode;
      funct3_d  = w_funct3;
      addrs_d   = w_add_rshift_type;
      rd_d      = w_rd;
      rs1_d     = w_rs1;
      rs2_d     = w_rs2;
      imm_d     = w_imm;
      illegal_d = w_illegal;
    end

    if (id_valid_q && !ex_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      pc_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      addrs_q     <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      pc_q        <= pc_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      addrs_q     <= addrs_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_valid           = id_valid_q;
  assign id_pc              = pc_q;
  assign id_opcode          = opcode_q;
  assign id_funct3          = funct3_q;
  assign id_add_rshift_type = addrs_q;
  assign id_rd              = rd_q;
  assign id_rs1             = rs1_q;
  assign id_rs2             = rs2_q;
  assign id_imm             = imm_q;
  assign id_illegal         = illegal_q;
  assign stall_cnt          = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage. Directed instruction
//            cases plus randomized traffic against a behavioural model of
//            the handshake and of RV32I field/immediate extraction.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_valid;
  logic             if_ready;
  logic [XLEN-1:0]  if_pc;
  logic [31:0]      if_inst;
  logic             flush;
  logic             ex_ready;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [6:0]       id_opcode;
  logic [2:0]       id_funct3;
  logic             id_add_rshift_type;
  logic [4:0]       id_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [XLEN-1:0]  id_imm;
  logic             id_illegal;
  logic [CNT_W-1:0] stall_cnt;

  decode_stage #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .if_valid           (if_valid),
    .if_ready           (if_ready),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .flush              (flush),
    .ex_ready           (ex_ready),
    .id_valid           (id_valid),
    .id_pc              (id_pc),
    .id_opcode          (id_opcode),
    .id_funct3          (id_funct3),
    .id_add_rshift_type (id_add_rshift_type),
    .id_rd              (id_rd),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_imm             (id_imm),
    .id_illegal         (id_illegal),
    .stall_cnt          (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: m_state 0 = data don't-care, 1 = holds m_inst,
  // 2 = reset values (all zero)
  bit          m_valid;
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  int          m_cnt;

  // --------------------------------------------------------------------------
  // Reference decode
  // --------------------------------------------------------------------------
  function automatic bit ref_legal(input logic [6:0] op);
    case (op)
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] inst);
    int s;
    logic [31:0] r;
    s = $signed(inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: r = 32'(s >>> 20);
      7'h23: r = 32'((s >>> 25) <<< 5) | 32'(inst[11:7]);
      7'h63: r = 32'((s >>> 31) <<< 12) | (32'(inst[7]) << 11) |
                 (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      7'h37, 7'h17: r = inst & 32'hFFFF_F000;
      7'h6F: r = 32'((s >>> 31) <<< 20) | (32'(inst[19:12]) << 12) |
                 (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic ref_addsub(input logic [31:0] inst);
    if (inst[6:0] == 7'h33) return inst[30];
    if (inst[6:0] == 7'h13 && inst[14:12] == 3'd5) return inst[30];
    return 1'b0;
  endfunction

  function automatic logic [4:0] ref_rd(input logic [31:0] inst);
    return (inst[6:0] == 7'h23 || inst[6:0] == 7'h63) ? 5'd0 : inst[11:7];
  endfunction

  function automatic logic [4:0] ref_rs1(input logic [31:0] inst);
    return (inst[6:0] == 7'h37 || inst[6:0] == 7'h17 || inst[6:0] == 7'h6F)
           ? 5'd0 : inst[19:15];
  endfunction

  function automatic logic [4:0] ref_rs2(input logic [31:0] inst);
    return (inst[6:0] == 7'h33 || inst[6:0] == 7'h23 || inst[6:0] == 7'h63)
           ? inst[24:20] : 5'd0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                             7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus primitives (no checking here)
  // --------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic fl,
                       input logic exr);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    flush    = fl;
    ex_ready = exr;
    #1;
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = if_valid && (!m_valid || ex_ready) && !flush;
    if (m_valid && !ex_ready && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      m_valid = 1'b0;
      m_state = 0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_state = 1;
      m_pc    = if_pc;
      m_inst  = if_inst;
    end else if (ex_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    #1;
    m_valid = 1'b0;
    m_state = 2;
    m_cnt   = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    assert_reset();
    repeat (2) @(posedge clk);
    release_reset();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", if_ready); end
    checks++; if ({id_pc, id_imm, id_opcode, id_rd, id_illegal} !== '0) begin
      errors++; $display("FAIL reset_fields got=%h/%h/%h/%h/%b exp=0", id_pc, id_imm, id_opcode, id_rd, id_illegal);
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h100, 32'hFFF0_0093, 1'b0, 1'b1);
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL addi_ready got=%b exp=1", if_ready); end
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", id_valid); end
    checks++; if (id_opcode !== 7'b0010011) begin errors++; $display("FAIL addi_opcode got=%b exp=0010011", id_opcode); end
    checks++; if (id_funct3 !== 3'b000) begin errors++; $display("FAIL addi_funct3 got=%b exp=000", id_funct3); end
    checks++; if (id_add_rshift_type !== 1'b0) begin errors++; $display("FAIL addi_addsub got=%b exp=0", id_add_rshift_type); end
    checks++; if (id_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", id_rd); end
    checks++; if (id_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got=%h exp=ffffffff", id_imm); end
    checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got=%h exp=100", id_pc); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h104, 32'h4030_D113, 1'b0, 1'b1);
    tick();
    checks++; if (id_add_rshift_type !== 1'b1) begin errors++; $display("FAIL srai_addsub got=%b exp=1", id_add_rshift_type); end
    checks++; if (id_funct3 !== 3'b101) begin errors++; $display("FAIL srai_funct3 got=%b exp=101", id_funct3); end
    checks++; if (id_imm !== 32'h403) begin errors++; $display("FAIL srai_imm got=%h exp=403", id_imm); end
    checks++; if ({id_rd, id_rs1} !== {5'd2, 5'd1}) begin errors++; $display("FAIL srai_regs got=%0d/%0d exp=2/1", id_rd, id_rs1); end
    drive(1'b1, 32'h108, 32'h4020_81B3, 1'b0, 1'b1);
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", if_ready); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h108) begin errors++; $display("FAIL sub_valid_pc got=%b/%h exp=1/108", id_valid, id_pc); end
    checks++; if (id_add_rshift_type !== 1'b1) begin errors++; $display("FAIL sub_addsub got=%b exp=1", id_add_rshift_type); end
    checks++; if ({id_rs1, id_rs2, id_rd} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL sub_regs got=%0d/%0d/%0d exp=1/2/3", id_rs1, id_rs2, id_rd);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++; if (id_valid !== 1'b0 || id_rd !== 5'd3) begin errors++; $display("FAIL drain got=%b/%0d exp=0/3", id_valid, id_rd); end
  endtask

  task automatic test_branch_lui();
    drive(1'b1, 32'h200, 32'hFE00_0EE3, 1'b0, 1'b1);
    tick();
    checks++; if (id_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_imm got=%h exp=fffffffc", id_imm); end
    checks++; if (id_rd !== 5'd0) begin errors++; $display("FAIL beq_rd got=%0d exp=0", id_rd); end
    drive(1'b1, 32'h204, 32'h1234_52B7, 1'b0, 1'b1);
    tick();
    checks++; if (id_imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm got=%h exp=12345000", id_imm); end
    checks++; if ({id_rs1, id_rd} !== {5'd0, 5'd5}) begin errors++; $display("FAIL lui_regs got=%0d/%0d exp=0/5", id_rs1, id_rd); end
  endtask

  task automatic test_stall_flush();
    assert_reset();
    release_reset();
    drive(1'b1, 32'h300, 32'h0050_0093, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, rand_inst(), 1'b0, 1'b0);
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, if_ready); end
      tick();
      checks++; if ({id_valid, id_pc, id_imm, id_rd} !== {1'b1, 32'h300, 32'h5, 5'd1}) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%0d exp=1/300/5/1", i, id_valid, id_pc, id_imm, id_rd);
      end
    end
    checks++; if (stall_cnt !== CNT_W'(5)) begin errors++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); end
    drive(1'b1, 32'h400, 32'h0010_0113, 1'b1, 1'b0);
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", id_valid); end
  endtask

  task automatic test_illegal_saturate();
    drive(1'b1, 32'h500, 32'h0000_007F, 1'b0, 1'b1);
    tick();
    checks++; if ({id_valid, id_illegal, id_imm, id_add_rshift_type} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL illegal got=%b/%b/%h/%b exp=1/1/0/0", id_valid, id_illegal, id_imm, id_add_rshift_type);
    end
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      drive(1'b1, $urandom, rand_inst(), 1'b0, 1'b0);
      tick();
    end
    checks++; if (stall_cnt !== '1) begin errors++; $display("FAIL cnt_sat got=%0d exp=%0d", stall_cnt, CNT_MAX); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (stall_cnt !== '1) begin errors++; $display("FAIL cnt_sat_hold got=%0d exp=%0d", stall_cnt, CNT_MAX); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] inst;
    logic [75:0] exp_v;
    logic [75:0] got_v;
    assert_reset();
    release_reset();
    for (int i = 0; i < 400; i++) begin
      pc   = $urandom;
      inst = rand_inst();
      drive($urandom_range(0, 3) != 0, pc, inst, $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) < 7);
      checks++; if (if_ready !== (!m_valid || ex_ready)) begin
        errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, if_ready, !m_valid || ex_ready);
      end
      tick();
      checks++; if (id_valid !== m_valid || stall_cnt !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got=%b/%0d exp=%b/%0d", i, id_valid, stall_cnt, m_valid, m_cnt);
      end
      if (m_state != 0) begin
        if (m_state == 1)
          exp_v = {m_pc, m_inst[6:0], m_inst[14:12], ref_addsub(m_inst), ref_rd(m_inst),
                   ref_rs1(m_inst), ref_rs2(m_inst), ref_imm(m_inst), !ref_legal(m_inst[6:0])};
        else
          exp_v = '0;
        got_v = {id_pc, id_opcode, id_funct3, id_add_rshift_type, id_rd, id_rs1, id_rs2, id_imm, id_illegal};
        checks++; if (got_v !== exp_v) begin
          errors++; $display("FAIL rnd_data[%0d] inst=%h got=%h exp=%h", i, m_inst, got_v, exp_v);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h600, 32'h0000_0013, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h604, 32'h0000_0013, 1'b0, 1'b0);
    repeat (3) tick();
    #2;
    assert_reset();
    checks++; if ({id_valid, stall_cnt, if_ready} !== {1'b0, CNT_W'(0), 1'b1}) begin
      errors++; $display("FAIL async_rst got=%b/%0d/%b exp=0/0/1", id_valid, stall_cnt, if_ready);
    end
    release_reset();
  endtask

  initial begin
    rst      = 1'b0;
    m_valid  = 1'b0;
    m_state  = 2;
    m_cnt    = 0;
    m_pc     = '0;
    m_inst   = '0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_lui();
    test_stall_flush();
    test_illegal_saturate();
    test_random();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
